// File: rtl/wordle_guess_ctrl.sv
// wordle_guess_ctrl
//   Game sequencer for the colour evaluator. Builds a 5-letter guess from typed
//   letters, holds it stable while the combinational evaluator runs, latches the
//   green/yellow result and commits it as one board row. Tracks the guess count
//   and reports win or lose.
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   new_game, answer_word start a game; answer sampled only on new_game
//   letter_vld/code       append a letter (codes above LETTER_MAX ignored)
//   backspace, submit     edit / evaluate the current guess
//   eval_greens/yellows   result from the evaluator for guess_word vs target_word
//   guess_word            current guess, letter i at [5i+4:5i]
//   target_word           registered answer
//   guess_len, row_idx    letters in the current row / current row
//   row_wr, row_greens,
//   row_yellows           one-cycle row commit with the latched colours
//   reject                one-cycle pulse on submit with fewer than 5 letters
//   game_won, game_lost   end-of-game levels
module wordle_guess_ctrl #(
  parameter int unsigned MAX_GUESSES = 6,
  parameter int unsigned LETTER_MAX  = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic [24:0] answer_word,
  input  logic        letter_vld,
  input  logic [4:0]  letter_code,
  input  logic        backspace,
  input  logic        submit,
  input  logic [4:0]  eval_greens,
  input  logic [4:0]  eval_yellows,
  output logic [24:0] guess_word,
  output logic [24:0] target_word,
  output logic [2:0]  guess_len,
  output logic [2:0]  row_idx,
  output logic        row_wr,
  output logic [4:0]  row_greens,
  output logic [4:0]  row_yellows,
  output logic        reject,
  output logic        game_won,
  output logic        game_lost
);

  typedef enum logic [2:0] {IDLE, ENTRY, EVAL, COMMIT, WON, LOST} state_t;

  localparam logic [2:0] LAST_ROW = 3'(MAX_GUESSES - 1);
  localparam logic [4:0] CODE_MAX = 5'(LETTER_MAX);

  state_t state, state_nxt;

  logic full;
  logic do_submit;
  logic do_back;
  logic do_letter;
  logic advance_row;

  // One action per cycle in ENTRY: a higher-priority request blocks the lower
  // ones even when it is itself refused (short submit, backspace at length 0).
  always_comb begin
    full        = (guess_len == 3'd5);
    do_submit   = (state == ENTRY) && !new_game && submit;
    do_back     = (state == ENTRY) && !new_game && !submit && backspace &&
                  (guess_len != 3'd0);
    do_letter   = (state == ENTRY) && !new_game && !submit && !backspace &&
                  letter_vld && !full && (letter_code <= CODE_MAX);
    advance_row = (state == COMMIT) && (row_greens != '1) && (row_idx != LAST_ROW);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = ENTRY;
    end else begin
      case (state)
        ENTRY:   if (submit && full) state_nxt = EVAL;
        EVAL:    state_nxt = COMMIT;
        COMMIT: begin
          if (row_greens == '1)         state_nxt = WON;
          else if (row_idx == LAST_ROW) state_nxt = LOST;
          else                          state_nxt = ENTRY;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // row_wr is qualified by rst so a reset landing on the COMMIT cycle
  // suppresses the write rather than letting it escape.
  always_comb begin
    row_wr    = (state == COMMIT) && !rst;
    game_won  = (state == WON);
    game_lost = (state == LOST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      guess_word  <= '0;
      target_word <= '0;
      guess_len   <= '0;
      row_idx     <= '0;
      row_greens  <= '0;
      row_yellows <= '0;
      reject      <= 1'b0;
    end else if (new_game) begin
      guess_word  <= '0;
      target_word <= answer_word;
      guess_len   <= '0;
      row_idx     <= '0;
      row_greens  <= '0;
      row_yellows <= '0;
      reject      <= 1'b0;
    end else begin
      reject <= do_submit && !full;
      if (do_letter) begin
        for (int unsigned i = 0; i < 5; i++)
          if (guess_len == 3'(i)) guess_word[5*i +: 5] <= letter_code;
        guess_len <= guess_len + 3'd1;
      end
      if (do_back) begin
        for (int unsigned i = 0; i < 5; i++)
          if (guess_len == 3'(i + 1)) guess_word[5*i +: 5] <= '0;
        guess_len <= guess_len - 3'd1;
      end
      if (state == EVAL) begin
        row_greens  <= eval_greens;
        row_yellows <= eval_yellows;
      end
      if (advance_row) begin
        row_idx    <= row_idx + 3'd1;
        guess_word <= '0;
        guess_len  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
module tb_wordle_guess_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, new_game, letter_vld, backspace, submit;
  logic [24:0] answer_word;
  logic [4:0]  letter_code, eval_greens, eval_yellows;
  logic [24:0] guess_word, target_word;
  logic [2:0]  guess_len, row_idx;
  logic        row_wr, reject, game_won, game_lost;
  logic [4:0]  row_greens, row_yellows;

  wordle_guess_ctrl #(.MAX_GUESSES(6), .LETTER_MAX(25)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .answer_word(answer_word),
    .letter_vld(letter_vld), .letter_code(letter_code), .backspace(backspace),
    .submit(submit), .eval_greens(eval_greens), .eval_yellows(eval_yellows),
    .guess_word(guess_word), .target_word(target_word), .guess_len(guess_len),
    .row_idx(row_idx), .row_wr(row_wr), .row_greens(row_greens),
    .row_yellows(row_yellows), .reject(reject), .game_won(game_won),
    .game_lost(game_lost)
  );

  typedef struct packed {
    logic ng; logic lv; logic [4:0] lc; logic bs; logic sb;
    logic [4:0] eg; logic [4:0] ey;
  } stim_t;

  typedef struct packed {
    logic [24:0] gw; logic [24:0] tw; logic [2:0] len; logic [2:0] row;
    logic wr; logic [4:0] g; logic [4:0] y; logic rej; logic won; logic lost;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  // CRANE: C=2 R=17 A=0 N=13 E=4, slot 0 in the low bits
  localparam logic [24:0] ANS = {5'd4, 5'd13, 5'd0, 5'd17, 5'd2};

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [24:0] pk(input logic [4:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic stim_t S(input logic ng, lv, input logic [4:0] lc,
                              input logic bs, sb, input logic [4:0] eg, ey);
    return '{ng, lv, lc, bs, sb, eg, ey};
  endfunction

  function automatic exp_t cur();
    return '{guess_word, target_word, guess_len, row_idx, row_wr, row_greens,
             row_yellows, reject, game_won, game_lost};
  endfunction

  task automatic add(input logic ng, lv, input logic [4:0] lc, input logic bs, sb,
                     input logic [4:0] eg, ey, input logic [24:0] gw,
                     input logic [2:0] len, row, input logic wr,
                     input logic [4:0] g, y, input logic rej, won, lost);
    vec_t v;
    v.s = S(ng, lv, lc, bs, sb, eg, ey);
    v.e = '{gw, ANS, len, row, wr, g, y, rej, won, lost};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // answer_word carries noise except on new_game so a leaky sample shows up
  task automatic drive(input stim_t s, input logic r);
    rst          = r;
    new_game     = s.ng;
    answer_word  = s.ng ? ANS : 25'($urandom);
    letter_vld   = s.lv;
    letter_code  = s.lc;
    backspace    = s.bs;
    submit       = s.sb;
    eval_greens  = s.eg;
    eval_yellows = s.ey;
    @(posedge clk);
    #1;
  endtask

  task automatic ng();                    drive(S(1, 0, 0, 0, 0, 0, 0), 1'b0); endtask
  task automatic letter(input logic [4:0] c); drive(S(0, 1, c, 0, 0, 0, 0), 1'b0); endtask
  task automatic sub();                   drive(S(0, 0, 0, 0, 1, 0, 0), 1'b0); endtask
  task automatic idle(input logic [4:0] g, y); drive(S(0, 0, 0, 0, 0, g, y), 1'b0); endtask
  task automatic type5(input logic [4:0] c);
    for (int k = 0; k < 5; k++) letter(c);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; new_game = 0; answer_word = '0; letter_vld = 0; letter_code = '0;
    backspace = 0; submit = 0; eval_greens = '0; eval_yellows = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 80'(cur()), 80'(0));
    rst = 1'b0;

    // ng lv lc bs sb eg ey | gw len row wr g y rej won lost
    add(1,0, 0,0,0, 0,0,     25'd0, 0,0,0, 0,0, 0,0,0);
    add(0,1, 2,0,0, 0,0,     pk(2,0,0,0,0), 1,0,0, 0,0, 0,0,0);
    add(0,1,17,0,0, 0,0,     pk(2,17,0,0,0), 2,0,0, 0,0, 0,0,0);
    add(0,1, 0,0,0, 0,0,     pk(2,17,0,0,0), 3,0,0, 0,0, 0,0,0);
    add(0,1,13,0,0, 0,0,     pk(2,17,0,13,0), 4,0,0, 0,0, 0,0,0);
    add(0,1, 4,0,0, 0,0,     ANS, 5,0,0, 0,0, 0,0,0);
    add(0,0, 0,0,1, 0,0,     ANS, 5,0,0, 0,0, 0,0,0);
    add(0,0, 0,0,0, 5'h1F,0, ANS, 5,0,1, 5'h1F,0, 0,0,0);
    add(0,0, 0,0,0, 0,0,     ANS, 5,0,0, 5'h1F,0, 0,1,0);
    add(0,1, 1,0,1, 0,0,     ANS, 5,0,0, 5'h1F,0, 0,1,0);
    add(1,0, 0,0,0, 0,0,     25'd0, 0,0,0, 0,0, 0,0,0);
    add(0,1, 1,0,0, 0,0,     pk(1,0,0,0,0), 1,0,0, 0,0, 0,0,0);
    add(0,1, 2,0,0, 0,0,     pk(1,2,0,0,0), 2,0,0, 0,0, 0,0,0);
    add(0,1, 3,0,0, 0,0,     pk(1,2,3,0,0), 3,0,0, 0,0, 0,0,0);
    add(0,0, 0,0,1, 0,0,     pk(1,2,3,0,0), 3,0,0, 0,0, 1,0,0);
    add(0,0, 0,0,0, 0,0,     pk(1,2,3,0,0), 3,0,0, 0,0, 0,0,0);
    add(0,1, 4,0,0, 0,0,     pk(1,2,3,4,0), 4,0,0, 0,0, 0,0,0);
    add(0,1, 5,0,0, 0,0,     pk(1,2,3,4,5), 5,0,0, 0,0, 0,0,0);
    add(0,1, 6,0,0, 0,0,     pk(1,2,3,4,5), 5,0,0, 0,0, 0,0,0);
    add(0,0, 0,1,0, 0,0,     pk(1,2,3,4,0), 4,0,0, 0,0, 0,0,0);
    add(0,1,27,0,0, 0,0,     pk(1,2,3,4,0), 4,0,0, 0,0, 0,0,0);
    add(0,1,25,0,0, 0,0,     pk(1,2,3,4,25), 5,0,0, 0,0, 0,0,0);
    add(0,1, 7,0,1, 0,0,     pk(1,2,3,4,25), 5,0,0, 0,0, 0,0,0);
    add(0,0, 0,0,0, 5'h03,5'h14, pk(1,2,3,4,25), 5,0,1, 5'h03,5'h14, 0,0,0);
    add(0,0, 0,0,0, 0,0,     25'd0, 0,1,0, 5'h03,5'h14, 0,0,0);
    add(0,0, 0,1,0, 0,0,     25'd0, 0,1,0, 5'h03,5'h14, 0,0,0);
    add(0,1, 0,0,0, 0,0,     25'd0, 1,1,0, 5'h03,5'h14, 0,0,0);
    add(0,1, 1,0,0, 0,0,     pk(0,1,0,0,0), 2,1,0, 5'h03,5'h14, 0,0,0);
    add(0,0, 0,1,0, 0,0,     25'd0, 1,1,0, 5'h03,5'h14, 0,0,0);
    add(0,1, 3,1,0, 0,0,     25'd0, 0,1,0, 5'h03,5'h14, 0,0,0);
    add(0,0, 0,1,1, 0,0,     25'd0, 0,1,0, 5'h03,5'h14, 1,0,0);
    add(0,0, 0,0,0, 0,0,     25'd0, 0,1,0, 5'h03,5'h14, 0,0,0);

    foreach (tbl[i]) begin
      sbq.push_back(tbl[i].e);
      drive(tbl[i].s, 1'b0);
      e = sbq.pop_front();
      chk($sformatf("vec%0d", i), 80'(cur()), 80'(e));
    end

    // six non-winning guesses, the last one lands in LOST
    ng();
    for (int r = 0; r < 6; r++) begin
      type5(5'd1);
      sub();
      chk($sformatf("eval_no_wr_r%0d", r), 80'(row_wr), 80'(0));
      idle(5'h0F, 5'(r + 1));
      chk($sformatf("commit_r%0d", r), 80'({row_wr, row_idx, row_greens, row_yellows}),
          80'({1'b1, 3'(r), 5'h0F, 5'(r + 1)}));
      idle(5'h00, 5'h00);
      if (r < 5)
        chk($sformatf("next_row_r%0d", r), 80'({row_idx, guess_len, guess_word, game_lost}),
            80'({3'(r + 1), 3'd0, 25'd0, 1'b0}));
      else
        chk("lost", 80'({row_idx, guess_word, game_lost, row_wr}),
            80'({3'd5, pk(1, 1, 1, 1, 1), 1'b1, 1'b0}));
    end
    letter(5'd2);
    sub();
    idle(5'h1F, 5'h00);
    chk("lost_ignores", 80'({guess_len, row_idx, game_lost, game_won, row_wr, reject}),
        80'({3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0}));

    // new_game on the EVAL cycle abandons the evaluation
    ng();
    type5(5'd3);
    sub();
    drive(S(1, 0, 0, 0, 0, 5'h1F, 0), 1'b0);
    chk("ng_in_eval", 80'({row_wr, row_idx, guess_len, guess_word, game_won}),
        80'({1'b0, 3'd0, 3'd0, 25'd0, 1'b0}));
    idle(5'h1F, 5'h00);
    chk("ng_in_eval_after", 80'({row_wr, game_won, row_greens}), 80'(0));

    // new_game on the COMMIT cycle: the row write still happens first
    type5(5'd4);
    sub();
    idle(5'h1F, 5'h00);
    chk("commit_before_ng", 80'({row_wr, row_greens}), 80'({1'b1, 5'h1F}));
    ng();
    chk("ng_in_commit", 80'({row_wr, game_won, row_idx, guess_len, row_greens, target_word}),
        80'({1'b0, 1'b0, 3'd0, 3'd0, 5'd0, ANS}));

    // rst landing in EVAL: nothing is committed, back to IDLE
    type5(5'd5);
    sub();
    drive(S(0, 0, 0, 0, 0, 5'h1F, 0), 1'b1);
    chk("rst_in_eval", 80'(cur()), 80'(0));
    idle(5'h1F, 5'h00);
    chk("idle_no_wr", 80'({row_wr, game_won}), 80'(0));
    letter(5'd6);
    chk("idle_ignores_letter", 80'({guess_len, guess_word}), 80'(0));

    // rst asserted during the COMMIT cycle suppresses row_wr
    ng();
    type5(5'd7);
    sub();
    idle(5'h00, 5'h00);
    rst = 1'b1;
    #1;
    chk("rst_in_commit_wr", 80'(row_wr), 80'(0));
    drive(S(0, 0, 0, 0, 0, 0, 0), 1'b1);
    chk("rst_in_commit", 80'(cur()), 80'(0));
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
